// File: rtl/gates_2x1_mux_selftest.sv
// Self-test sequencer for the 2x1-mux all-gates block: walks {a,b} through
// 00..11, lets each vector settle, then scores the seven gate outputs.
module gates_2x1_mux_selftest #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y_and,
  input  logic       y_or,
  input  logic       y_not,
  input  logic       y_nand,
  input  logic       y_nor,
  input  logic       y_xor,
  input  logic       y_xnor,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [3:0] fail_vec,
  output logic [6:0] fail_gate
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic       a_q, a_d, b_q, b_d;
  logic       busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [4:0] err_q, err_d;
  logic [3:0] fvec_q, fvec_d;
  logic [6:0] fgate_q, fgate_d;

  logic [6:0] y_obs, y_exp, mism;
  logic [2:0] pop;
  logic [1:0] vec_nxt;

  assign y_obs = {y_xnor, y_xor, y_nor, y_nand, y_not, y_or, y_and};
  assign y_exp = {~(a_q ^ b_q), a_q ^ b_q, ~(a_q | b_q), ~(a_q & b_q),
                  ~a_q, a_q | b_q, a_q & b_q};
  assign mism    = y_obs ^ y_exp;
  assign vec_nxt = vec_q + 2'd1;

  always_comb begin
    pop = '0;
    for (int i = 0; i < 7; i++) pop = pop + 3'(mism[i]);
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    fvec_d  = fvec_q;
    fgate_d = fgate_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SETTLE;
        vec_d   = '0;
        cnt_d   = '0;
        a_d     = 1'b0;
        b_d     = 1'b0;
        busy_d  = 1'b1;
        pass_d  = 1'b0;
        err_d   = '0;
        fvec_d  = '0;
        fgate_d = '0;
      end
      SETTLE: begin
        if (cnt_q == CNT_LAST) state_d = CHECK;
        else                   cnt_d   = cnt_q + 4'd1;
      end
      CHECK: begin
        // 4 vectors x 7 gates = 28 max, so 5 bits never wrap
        err_d         = err_q + 5'(pop);
        fgate_d       = fgate_q | mism;
        fvec_d[vec_q] = |mism;
        if (vec_q == 2'd3) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          state_d = SETTLE;
          vec_d   = vec_nxt;
          a_d     = vec_nxt[1];
          b_d     = vec_nxt[0];
          cnt_d   = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fvec_q  <= '0;
      fgate_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fvec_q  <= fvec_d;
      fgate_q <= fgate_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fvec_q;
  assign fail_gate = fgate_q;

endmodule

// File: tb/tb_gates_2x1_mux_selftest.sv
// Bench: three self-testers (SETTLE_CYCLES 2, 1, 15) each driving a gate block
// model with injectable stuck-at-0 / stuck-at-1 / invert faults per gate.
module tb_gates_2x1_mux_selftest;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [6:0] inv = '0, f0 = '0, f1 = '0;
  logic       start_v [3];
  logic       a_v [3], b_v [3], busy_v [3], done_v [3], pass_v [3];
  logic [4:0] err_v [3];
  logic [3:0] fvec_v [3];
  logic [6:0] fgate_v [3];

  int checks = 0;
  int errors = 0;

  function automatic int sc(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  // Ideal gate outputs from arithmetic on a,b; bit order and,or,not,nand,nor,xor,xnor
  function automatic logic [6:0] ideal(input int av, input int bv);
    logic [6:0] r;
    r[0] = (av * bv) == 1;
    r[1] = (av + bv) > 0;
    r[2] = av == 0;
    r[3] = (av * bv) == 0;
    r[4] = (av + bv) == 0;
    r[5] = (av + bv) == 1;
    r[6] = (av + bv) != 1;
    return r;
  endfunction

  function automatic logic [6:0] faulty(input logic av, input logic bv,
      input logic [6:0] iv, input logic [6:0] z, input logic [6:0] o);
    return ((ideal(int'(av), int'(bv)) ^ iv) & ~z) | o;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    logic [6:0] y;
    assign y = faulty(a_v[gi], b_v[gi], inv, f0, f1);
    gates_2x1_mux_selftest #(.SETTLE_CYCLES(sc(gi))) u_dut (
      .clk(clk), .rst(rst), .start(start_v[gi]),
      .y_and(y[0]), .y_or(y[1]), .y_not(y[2]), .y_nand(y[3]),
      .y_nor(y[4]), .y_xor(y[5]), .y_xnor(y[6]),
      .a(a_v[gi]), .b(b_v[gi]), .busy(busy_v[gi]), .done(done_v[gi]),
      .pass(pass_v[gi]), .err_count(err_v[gi]), .fail_vec(fvec_v[gi]),
      .fail_gate(fgate_v[gi])
    );
  end

  // Runs one pass on DUT d; optionally re-pulses start k cycles after acceptance
  task automatic do_pass(input int d, input string name, input int repulse_k);
    int exp_err = 0;
    logic [3:0] exp_vec = '0;
    logic [6:0] exp_gate = '0;
    int s = sc(d);
    int lat = 4 * (s + 1);
    int k = 0;
    bit seq_bad = 0, got_done = 0;
    for (int v = 0; v < 4; v++) begin
      logic [6:0] id, m;
      id = ideal(v / 2, v % 2);
      m = (((id ^ inv) & ~f0) | f1) ^ id;
      exp_err += $countones(m);
      exp_vec[v] = |m;
      exp_gate |= m;
    end
    @(negedge clk); start_v[d] = 1'b1;
    @(posedge clk); #1; start_v[d] = 1'b0;
    while (k <= lat + 4) begin
      if (k < lat) begin
        if (a_v[d] !== 1'((k / (s + 1)) / 2) || b_v[d] !== 1'((k / (s + 1)) % 2) ||
            busy_v[d] !== 1'b1 || done_v[d] !== 1'b0) seq_bad = 1;
      end
      if (k == repulse_k) begin
        start_v[d] = 1'b1;
        @(posedge clk); #1; start_v[d] = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
      k++;
      if (done_v[d] === 1'b1) begin got_done = 1; break; end
    end
    checks++;
    if (seq_bad) begin
      errors++; $display("FAIL %s seq: a/b/busy sequence wrong, want 00,01,10,11 x%0d", name, s + 1);
    end
    checks++;
    if (!got_done || k != lat) begin
      errors++; $display("FAIL %s latency: got %0d (done=%0b), want %0d", name, k, got_done, lat);
    end
    checks++;
    if (pass_v[d] !== (exp_err == 0) || busy_v[d] !== 1'b0) begin
      errors++; $display("FAIL %s pass: got pass=%b busy=%b, want pass=%0b busy=0",
                         name, pass_v[d], busy_v[d], exp_err == 0);
    end
    checks++;
    if (err_v[d] !== 5'(exp_err) || fvec_v[d] !== exp_vec || fgate_v[d] !== exp_gate) begin
      errors++; $display("FAIL %s stats: got err=%0d vec=%b gate=%b, want err=%0d vec=%b gate=%b",
                         name, err_v[d], fvec_v[d], fgate_v[d], exp_err, exp_vec, exp_gate);
    end
    @(posedge clk); #1;
    checks++;
    if (done_v[d] !== 1'b0 || pass_v[d] !== (exp_err == 0) || err_v[d] !== 5'(exp_err)) begin
      errors++; $display("FAIL %s hold: got done=%b pass=%b err=%0d, want done=0 pass=%0b err=%0d",
                         name, done_v[d], pass_v[d], err_v[d], exp_err == 0, exp_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({a_v[d], b_v[d], busy_v[d], done_v[d], pass_v[d]} !== 5'b0 ||
          err_v[d] !== '0 || fvec_v[d] !== '0 || fgate_v[d] !== '0) begin
        errors++; $display("FAIL reset%0d: got ab=%b%b busy=%b done=%b pass=%b err=%0d, want all 0",
                           d, a_v[d], b_v[d], busy_v[d], done_v[d], pass_v[d], err_v[d]);
      end
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic set_faults(input logic [6:0] i, input logic [6:0] z, input logic [6:0] o);
    inv = i; f0 = z; f1 = o;
  endtask

  task automatic test_fault_free();
    set_faults('0, '0, '0);
    do_pass(0, "clean_s2", -1);
    do_pass(1, "clean_s1", -1);
    do_pass(2, "clean_s15", -1);
  endtask

  task automatic test_faults();
    set_faults('0, 7'b0000001, '0);
    do_pass(0, "and_sa0", -1);
    set_faults(7'b0100000, '0, '0);
    do_pass(0, "xor_inv", -1);
    set_faults(7'b0100000, '0, 7'b0000100);
    do_pass(0, "xor_inv_not_sa1", -1);
  endtask

  task automatic test_back_to_back();
    set_faults(7'b0100000, '0, '0);
    do_pass(0, "restart_ignored", 3);
    set_faults('0, '0, '0);
    do_pass(0, "b2b_clean", -1);
  endtask

  task automatic test_reset_mid();
    bit saw_done = 0;
    set_faults(7'b0000001, '0, '0);
    @(negedge clk); start_v[0] = 1'b1;
    @(posedge clk); #1; start_v[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (a_v[0] !== 1'b1 || b_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
      errors++; $display("FAIL midrst_pre: got ab=%b%b busy=%b, want ab=10 busy=1", a_v[0], b_v[0], busy_v[0]);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({a_v[0], b_v[0], busy_v[0], done_v[0], pass_v[0]} !== 5'b0 ||
        err_v[0] !== '0 || fvec_v[0] !== '0 || fgate_v[0] !== '0) begin
      errors++; $display("FAIL midrst: got ab=%b%b busy=%b done=%b err=%0d vec=%b, want all 0",
                         a_v[0], b_v[0], busy_v[0], done_v[0], err_v[0], fvec_v[0]);
    end
    @(negedge clk); rst = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done_v[0] === 1'b1) saw_done = 1;
    end
    checks++;
    if (saw_done || busy_v[0] !== 1'b0) begin
      errors++; $display("FAIL midrst_quiet: got done_seen=%0b busy=%b, want 0 0", saw_done, busy_v[0]);
    end
    set_faults('0, '0, '0);
    do_pass(0, "after_rst", -1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      int d = int'($urandom_range(0, 2));
      set_faults(7'($urandom) & 7'($urandom), 7'($urandom) & 7'($urandom), 7'($urandom) & 7'($urandom));
      do_pass(d, $sformatf("rand%0d", n), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1);
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) start_v[d] = 1'b0;
    test_reset();
    test_fault_free();
    test_faults();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gates_2x1_mux_selftest.md
Name: gates_2x1_mux_selftest

Overview:
Sequential stimulus and checker stage wrapped around the 2x1-mux all-gates block. It drives the block's a/b inputs through all four input combinations, waits a settle interval, and compares the seven gate outputs against the ideal truth table. It accumulates mismatch statistics and reports pass/fail. It is the on-board self-test used with switch/LED bring-up.

Parameters:
SETTLE_CYCLES, 2, clock cycles each vector is held before outputs are compared; legal range 1..15.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  synchronous active-high reset
start  input  1  single-cycle request to run a test pass; sampled only in IDLE
y_and  input  1  AND output from block under test
y_or  input  1  OR output
y_not  input  1  NOT output (inverse of a)
y_nand  input  1  NAND output
y_nor  input  1  NOR output
y_xor  input  1  XOR output
y_xnor  input  1  XNOR output
a  output  1  stimulus a to block under test (registered)
b  output  1  stimulus b to block under test (registered)
busy  output  1  high while a test pass is running
done  output  1  one-cycle pulse when the pass completes
pass  output  1  1 when the last completed pass had zero mismatches; held until the next start
err_count  output  5  total mismatched output bits in the last pass (0..28)
fail_vec  output  4  bit v set if any output mismatched for vector v = {a,b}
fail_gate  output  7  sticky per-gate mismatch flags; bit order [0]and [1]or [2]not [3]nand [4]nor [5]xor [6]xnor

Behaviour:
- Clocking and reset: one clock domain. rst is synchronous, active-high, and fully registered.
- Reset values: state=IDLE; a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, fail_gate=0; internal vec=0, settle counter=0.
- Reset mid-pass: aborts the pass immediately to the reset values; done is not pulsed.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - start=1 at an edge: go to SETTLE with vec=0, a=0, b=0, counter=0, busy=1.
  - err_count, fail_vec, fail_gate and pass are cleared on the same edge.
  - start=0: outputs hold.
- SETTLE: counter increments each cycle. When counter==SETTLE_CYCLES-1, go to CHECK. The SETTLE state therefore lasts exactly SETTLE_CYCLES cycles.
- CHECK: lasts one cycle. Gate inputs are compared combinationally against expected values computed from the current a,b:
  - and=a&b, or=a|b, not=~a, nand=~(a&b), nor=~(a|b), xor=a^b, xnor=~(a^b).
  - At the edge: err_count += popcount(mismatch[6:0]); fail_gate |= mismatch; fail_vec[vec] = |mismatch.
  - If vec==3, go to DONE.
  - Otherwise vec+1, drive a=vec_next[1], b=vec_next[0], clear counter, and go to SETTLE.
- Vector order: {a,b} = 00, 01, 10, 11.
- DONE: lasts one cycle with done=1, busy=0, pass=(err_count==0), then returns to IDLE. pass and the statistics hold until the next accepted start.
- Latency: from the edge accepting start to the edge entering DONE is 4*(SETTLE_CYCLES+1) cycles. This is 12 cycles at the default.
- start while busy or in DONE: ignored, with no restart or clearing.
- A start asserted in the cycle after DONE (i.e. in IDLE) is accepted normally, allowing back-to-back passes.
- Inputs are sampled only in CHECK; activity on the y_* inputs during SETTLE has no effect.
- err_count cannot overflow: max 28 fits 5 bits, so no saturation logic is needed.
- a,b change only on the edge leaving CHECK (or accepting start) and are constant throughout SETTLE and CHECK.

Test Plan:
- Fault-free DUT connected, SETTLE_CYCLES=2, start pulse -> a/b sequence 00,01,10,11 each held 3 cycles; done pulses 12 cycles after the start edge; pass=1, err_count=0, fail_vec=0000, fail_gate=0000000.
- y_and stuck at 0 -> only vector 11 fails; pass=0, err_count=1, fail_vec=1000, fail_gate=0000001.
- y_xor inverted -> every vector fails; err_count=4, fail_vec=1111, fail_gate=0100000; y_not stuck at 1 added on top -> err_count=6, fail_vec=1111, fail_gate=0100100.
- start re-pulsed during SETTLE of vector 01 -> no restart; done still occurs at cycle 12 with unchanged results. A second start after done, with a fault-free DUT -> results from the first failing run are cleared and pass=1.
- rst asserted during CHECK of vector 10 -> next cycle state IDLE, a=b=0, busy=0, all statistics 0, no done pulse. A following start runs a full 12-cycle pass.
- SETTLE_CYCLES=1 and 15 -> done at 8 and 64 cycles respectively after the start edge, with correct pass for a fault-free DUT.
